// File: rtl/output_collector.sv
// Output collector: captures convolution results into a small FIFO, requantizes
// them by shift-and-saturate, and writes one frame row-major over a ready/valid port.
module output_collector #(
    parameter int OUT_BIN_LEN   = 16,
    parameter int BIN_LEN       = 8,
    parameter int INPUT_WIDTH   = 8,
    parameter int INPUT_HEIGHT  = 8,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int SHIFT         = 0,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_W        = 6
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [OUT_BIN_LEN-1:0] in_val,
    input  logic                   in_valid,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [BIN_LEN-1:0]     wr_data,
    input  logic                   wr_ready,
    output logic                   overflow,
    output logic                   frame_done
);

    localparam int OUT_W = INPUT_WIDTH - KERNEL_WIDTH + 1;
    localparam int OUT_H = INPUT_HEIGHT - KERNEL_HEIGHT + 1;
    localparam int TOTAL = OUT_W * OUT_H;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [OUT_BIN_LEN-1:0] MAX_Q = OUT_BIN_LEN'((1 << BIN_LEN) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state, state_next;
    logic [OUT_BIN_LEN-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic [PTR_W:0]         fifo_cnt;
    logic [CNT_W-1:0]       acc_cnt;
    logic [ADDR_W-1:0]      load_idx;

    logic                   fifo_empty, fifo_full, out_free, pop, capture, push, drop, start_ok;
    logic [OUT_BIN_LEN-1:0] shifted;
    logic [BIN_LEN-1:0]     q_sat;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    // The output register can take a new value when empty or when its write is accepted.
    assign out_free   = !wr_en || wr_ready;
    assign pop        = out_free && !fifo_empty;
    assign capture    = (state == RUN) && in_valid;
    assign push       = capture && (!fifo_full || pop);
    assign drop       = capture && fifo_full && !pop;
    assign start_ok   = start && ((state == IDLE) || (state == DONE));

    assign shifted = fifo_mem[rd_ptr] >> SHIFT;
    assign q_sat   = (shifted > MAX_Q) ? '1 : shifted[BIN_LEN-1:0];

    always_comb begin
        // NOTE: next-state defaults to the current state so no path leaves it unassigned (no latch).
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (capture && acc_cnt == CNT_W'(TOTAL - 1)) state_next = DRAIN;
            DRAIN:      if (fifo_empty && out_free) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // NOTE: FIFO storage has no reset; occupancy is tracked by the reset counters, so stale data is never read.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= in_val;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_cnt   <= '0;
            acc_cnt    <= '0;
            load_idx   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_cnt   <= '0;
                acc_cnt    <= '0;
                load_idx   <= '0;
                wr_en      <= 1'b0;
                wr_addr    <= '0;
                wr_data    <= '0;
                overflow   <= 1'b0;
                frame_done <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                    2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                    default: fifo_cnt <= fifo_cnt;
                endcase
                // Dropped samples still count toward the frame total.
                if (capture) acc_cnt <= acc_cnt + CNT_W'(1);
                if (drop) overflow <= 1'b1;
                if (state == DRAIN && state_next == DONE) frame_done <= 1'b1;
                if (out_free) begin
                    wr_en <= pop;
                    if (pop) begin
                        wr_data  <= q_sat;
                        wr_addr  <= load_idx;
                        load_idx <= load_idx + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_output_collector.sv
// Self-checking bench for output_collector: randomized frames compared against a
// transaction-level model of capture, drop, requantization and write ordering.
module tb_output_collector;

    localparam int SHIFT = 2;
    localparam int DEPTH = 4;
    localparam int TOTAL = (8 - 3 + 1) * (8 - 3 + 1);
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_val = '0;
    logic        in_valid = 1'b0;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready = 1'b0;
    logic        overflow;
    logic        frame_done;

    output_collector #(.SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .in_val(in_val),
        .in_valid(in_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .overflow(overflow), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    int cyc = 0, last_hs = -1, done_cyc = -1, hold_err = 0;
    int got_addr[$], got_data[$], exp_data[$];
    logic       obs_en, obs_ovf, obs_done;
    logic [5:0] obs_addr, prev_addr;
    logic [7:0] obs_data, prev_data;
    bit         prev_stall = 0;

    // Reference model: frame phase, items held in the FIFO, and whether the write slot is occupied.
    int m_phase = P_IDLE, m_fifo_n = 0, m_acc = 0, m_drops = 0;
    bit m_out_valid = 0, m_overflow = 0;

    function automatic int requant(int v);
        int q = v / (1 << SHIFT);
        return (q > 255) ? 255 : q;
    endfunction

    task automatic model_clear(input int phase);
        m_phase = phase; m_fifo_n = 0; m_acc = 0; m_drops = 0;
        m_out_valid = 0; m_overflow = 0;
        got_addr.delete(); got_data.delete(); exp_data.delete();
        done_cyc = -1; last_hs = -1; prev_stall = 0; hold_err = 0;
    endtask

    // One clock cycle: drive inputs, sample outputs at negedge, advance the model, move past posedge.
    task automatic cycle(input bit v, input logic [15:0] val, input bit rdy, input bit st);
        bit free, pop, keep;
        in_valid = v; in_val = val; wr_ready = rdy; start = st;
        @(negedge clock);
        obs_en = wr_en; obs_addr = wr_addr; obs_data = wr_data;
        obs_ovf = overflow; obs_done = frame_done;
        if (wr_en === 1'b1 && rdy) begin
            got_addr.push_back(int'(wr_addr)); got_data.push_back(int'(wr_data)); last_hs = cyc;
        end
        if (prev_stall && (wr_en !== 1'b1 || wr_addr !== prev_addr || wr_data !== prev_data))
            hold_err++;
        prev_stall = (wr_en === 1'b1) && !rdy; prev_addr = wr_addr; prev_data = wr_data;
        if (frame_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (st && (m_phase == P_IDLE || m_phase == P_DONE)) begin
            model_clear(P_RUN);
        end else begin
            free = !m_out_valid || rdy;
            pop  = free && (m_fifo_n > 0);
            keep = 0;
            if (m_phase == P_RUN && v) begin
                m_acc++;
                if (m_fifo_n < DEPTH || pop) keep = 1;
                else begin m_overflow = 1; m_drops++; end
            end
            if (free) m_out_valid = pop;
            if (pop) m_fifo_n--;
            if (keep) begin m_fifo_n++; exp_data.push_back(requant(int'(val))); end
            if (m_phase == P_RUN && m_acc == TOTAL) m_phase = P_DRAIN;
            else if (m_phase == P_DRAIN && m_fifo_n == 0 && !m_out_valid) m_phase = P_DONE;
        end
        @(posedge clock); #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 0; in_valid = 0; in_val = '0; wr_ready = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        model_clear(P_IDLE);
    endtask

    // Send pulses until the model has seen a full frame; rand_* selects random valid/ready.
    task automatic feed(input bit rand_v, input bit rand_r, input bit rand_st);
        for (int n = 0; n < 600 && m_acc < TOTAL; n++)
            cycle(rand_v ? ($urandom_range(0, 1) == 1) : 1'b1, 16'($urandom),
                  rand_r ? ($urandom_range(0, 9) < 7) : 1'b1,
                  rand_st ? ($urandom_range(0, 19) == 0) : 1'b0);
    endtask

    task automatic drain(input string name, input bit rand_r);
        for (int n = 0; n < 80 && obs_done !== 1'b1; n++)
            cycle(1'b0, 16'h0, rand_r ? ($urandom_range(0, 1) == 1) : 1'b1, 1'b0);
        checks++;
        if (obs_done !== 1'b1) begin
            errors++; $display("FAIL %s frame_done timeout got %b exp 1", name, obs_done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, overflow, frame_done} !== 17'h0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {wr_en, wr_addr, wr_data, overflow, frame_done});
        end
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0123, 1'b1, 1'b0);
        checks++;
        if (obs_en !== 1'b0 || got_data.size() != 0) begin
            errors++; $display("FAIL idle_drop wr_en got %b writes %0d exp 0 0", obs_en, got_data.size());
        end
        checks++;
        if (obs_ovf !== 1'b0 || obs_done !== 1'b0) begin
            errors++; $display("FAIL idle_flags got ovf %b done %b exp 0 0", obs_ovf, obs_done);
        end
    endtask

    task automatic test_latency();
        do_reset();
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        cycle(1'b1, 16'h0123, 1'b1, 1'b0);
        checks++;
        if (obs_en !== 1'b0) begin errors++; $display("FAIL latency_t0 wr_en got %b exp 0", obs_en); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (obs_en !== 1'b0) begin errors++; $display("FAIL latency_t1 wr_en got %b exp 0", obs_en); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (obs_en !== 1'b1 || obs_addr !== 6'd0 || obs_data !== 8'h48) begin
            errors++; $display("FAIL latency_t2 got en %b addr %0d data %h exp 1 0 48", obs_en, obs_addr, obs_data);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] vals [3];
        logic [7:0]  want [3];
        vals = '{16'h0800, 16'h03FC, 16'h03F8};
        want = '{8'hFF, 8'hFF, 8'hFE};
        do_reset();
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, vals[i], 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (got_data.size() != 3) begin errors++; $display("FAIL sat_count got %0d exp 3", got_data.size()); end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] != int'(want[i]) || got_addr[i] != i) begin
                errors++; $display("FAIL sat[%0d] got addr %0d data %h exp %0d %h", i, got_addr[i], got_data[i], i, want[i]);
            end
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        feed(1'b0, 1'b0, 1'b0);
        drain("full_frame", 1'b0);
        checks++;
        if (got_data.size() != TOTAL || exp_data.size() != TOTAL) begin
            errors++; $display("FAIL full_count got %0d exp %0d", got_data.size(), TOTAL);
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_addr[i] != i || got_data[i] != exp_data[i]) begin
                errors++; $display("FAIL full[%0d] got addr %0d data %h exp %0d %h", i, got_addr[i], got_data[i], i, exp_data[i]);
            end
        end
        checks++;
        if (done_cyc != last_hs + 1) begin
            errors++; $display("FAIL full_done_timing got cycle %0d exp %0d", done_cyc, last_hs + 1);
        end
        checks++;
        if (obs_ovf !== 1'b0) begin errors++; $display("FAIL full_overflow got %b exp 0", obs_ovf); end
    endtask

    task automatic test_stall_overflow();
        do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (obs_ovf !== 1'b1) begin errors++; $display("FAIL stall_overflow got %b exp 1", obs_ovf); end
        checks++;
        if (hold_err != 0 || obs_en !== 1'b1) begin
            errors++; $display("FAIL stall_hold got changes %0d en %b exp 0 1", hold_err, obs_en);
        end
        feed(1'b0, 1'b0, 1'b0);
        drain("stall", 1'b0);
        checks++;
        if (got_data.size() != TOTAL - m_drops || exp_data.size() != TOTAL - m_drops) begin
            errors++; $display("FAIL stall_count got %0d exp %0d", got_data.size(), TOTAL - m_drops);
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_addr[i] != i || got_data[i] != exp_data[i]) begin
                errors++; $display("FAIL stall[%0d] got addr %0d data %h exp %0d %h", i, got_addr[i], got_data[i], i, exp_data[i]);
            end
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (obs_ovf !== 1'b0) begin errors++; $display("FAIL pushpop_overflow got %b exp 0", obs_ovf); end
        feed(1'b0, 1'b0, 1'b0);
        drain("pushpop", 1'b0);
        checks++;
        if (got_data.size() != TOTAL || obs_ovf !== 1'b0) begin
            errors++; $display("FAIL pushpop_count got %0d ovf %b exp %0d 0", got_data.size(), obs_ovf, TOTAL);
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_addr[i] != i || got_data[i] != exp_data[i]) begin
                errors++; $display("FAIL pushpop[%0d] got addr %0d data %h exp %0d %h", i, got_addr[i], got_data[i], i, exp_data[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b1);
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
            checks++;
            if (obs_done !== 1'b0 || obs_ovf !== 1'b0) begin
                errors++; $display("FAIL rand%0d_clear got done %b ovf %b exp 0 0", f, obs_done, obs_ovf);
            end
            feed(1'b1, 1'b1, 1'b1);
            drain("random", 1'b1);
            checks++;
            if (obs_ovf !== m_overflow || got_data.size() != exp_data.size()) begin
                errors++; $display("FAIL rand%0d_summary got ovf %b writes %0d exp %b %0d", f, obs_ovf, got_data.size(), m_overflow, exp_data.size());
            end
            for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
                checks++;
                if (got_addr[i] != i || got_data[i] != exp_data[i]) begin
                    errors++; $display("FAIL rand%0d[%0d] got addr %0d data %h exp %0d %h", f, i, got_addr[i], got_data[i], i, exp_data[i]);
                end
            end
            checks++;
            if (done_cyc != last_hs + 1 || hold_err != 0) begin
                errors++; $display("FAIL rand%0d_done_hold got cycle %0d holds %0d exp %0d 0", f, done_cyc, hold_err, last_hs + 1);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        for (int n = 0; n < 40 && !(obs_en === 1'b1 && obs_addr == 6'd17); n++)
            cycle(1'b1, 16'($urandom) | 16'h0100, 1'b1, 1'b0);
        checks++;
        if (obs_addr !== 6'd17) begin errors++; $display("FAIL midreset_reach got addr %0d exp 17", obs_addr); end
        reset_n = 1'b0; #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, overflow, frame_done} !== 17'h0) begin
            errors++; $display("FAIL midreset_async got %h exp 0", {wr_en, wr_addr, wr_data, overflow, frame_done});
        end
        @(posedge clock); #1 reset_n = 1'b1;
        model_clear(P_IDLE);
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        cycle(1'b1, 16'h0456, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (got_addr.size() != 1 || exp_data.size() != 1) begin
            errors++; $display("FAIL midreset_count got %0d exp 1", got_addr.size());
        end else if (got_addr[0] != 0 || got_data[0] != exp_data[0]) begin
            errors++; $display("FAIL midreset_restart got addr %0d data %h exp 0 %h", got_addr[0], got_data[0], exp_data[0]);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_saturation();
        test_full_frame();
        test_stall_overflow();
        test_full_push_pop();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
